mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that acts as a responder on the processor's data-memory bus (`address_to_mem`, `data_to_mem`, `write_enable`). Stores to its address window enqueue bytes into a small FIFO, and loads return status. A serializer drains the FIFO onto an 8N1 serial line. The block sits beside `dmem` in `top` and gives programs a way to emit output.

---
 rtl/mmio_pkg.sv | 21 ++
 rtl/mmio_uart_tx_if.sv | 21 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/mmio_uart_tx.sv | 146 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout and serializer states.
package mmio_pkg;

  localparam logic [3:0] TXDATA_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus as seen by an MMIO responder.
// Handshake: there is no backpressure. A store is write_enable high for one
// cycle and is taken at that rising edge when sel is high; sel and read_data
// are combinational on the current address.
interface mmio_uart_tx_if;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic        write_enable;
  logic        sel;
  logic [31:0] read_data;

  modport master (
    output address_to_mem, data_to_mem, write_enable,
    input  sel, read_data
  );

  modport slave (
    input  address_to_mem, data_to_mem, write_enable,
    output sel, read_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: stores to TXDATA queue bytes, STATUS reports state,
// and an 8N1 serializer drains the queue with no gap between frames.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  mmio_uart_tx_if.slave    bus,
  output logic             tx,
  output tx_state_e        dbg_state
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e      state, state_n;
  logic [TW-1:0]  bit_cnt, bit_cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shreg, shreg_n;
  logic           pop;
  logic           bit_done;
  logic           ovf;
  logic           ovf_set;
  logic           wr_txdata;
  logic           wr_status;
  logic [3:0]     ofs;
  logic [7:0]     pop_data;
  logic           full, empty;
  logic [CW-1:0]  count;
  logic [31:0]    status;
  logic           unused_bus_bits;

  assign unused_bus_bits = ^{bus.data_to_mem[31:8], bus.address_to_mem[1:0]};

  assign ofs       = {bus.address_to_mem[3:2], 2'b00};
  assign bus.sel   = (bus.address_to_mem[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata = bus.write_enable && bus.sel && (ofs == TXDATA_OFS);
  assign wr_status = bus.write_enable && bus.sel && (ofs == STATUS_OFS);
  // Drop happens only when no pop frees a slot in this same cycle.
  assign ovf_set   = wr_txdata && full && !pop;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (wr_txdata),
    .push_data (bus.data_to_mem[7:0]),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      if (ovf_set)                                ovf <= 1'b1;
      else if (wr_status && bus.data_to_mem[STAT_OVF]) ovf <= 1'b0;
    end
  end

  assign bit_done = (bit_cnt == TW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_done ? '0 : bit_cnt + TW'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        bit_cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = pop_data;
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        // Reload straight from the stop bit so consecutive frames abut.
        if (bit_done) begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = pop_data;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      default: tx = 1'b1;
    endcase
  end

  assign dbg_state = state;

  always_comb begin
    status                          = '0;
    status[STAT_BUSY]               = (state != IDLE) || !empty;
    status[STAT_FULL]               = full;
    status[STAT_EMPTY]              = empty;
    status[STAT_OVF]                = ovf;
    status[STAT_COUNT_LSB +: 4]     = 4'(count);
  end

  always_comb begin
    bus.read_data = '0;
    if (bus.sel && (ofs == STATUS_OFS)) bus.read_data = status;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed stores/loads plus a serial-line monitor
// that decodes frames and checks them against an expected-byte queue.
module tb_mmio_uart_tx;
  import mmio_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam int          CPB  = 4;

  logic      clk = 1'b0;
  logic      reset;
  logic      tx;
  tx_state_e dbg_state;
  int        cyc = 0;
  int        n_tests = 0;
  int        n_fail = 0;
  logic [7:0] exp_q[$];

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .tx        (tx),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address_to_mem = addr;
    bus.data_to_mem    = data;
    bus.write_enable   = 1'b1;
    @(negedge clk);
    bus.write_enable   = 1'b0;
    bus.address_to_mem = 32'h0;
    bus.data_to_mem    = 32'h0;
  endtask

  task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data);
    bus.address_to_mem = addr;
    #1;
    data = bus.read_data;
  endtask

  task automatic expect_idle_line(input string name, input int cycles);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
    check(name, ok, 1'b1);
  endtask

  // serial monitor / scoreboard
  initial begin : monitor
    logic [7:0] rx;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        rx = '0;
        aborted = 1'b0;
        for (int c = 1; c < 10 * CPB; c++) begin
          @(negedge clk);
          if (reset !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (c == 2) check("start_bit", tx, 1'b0);
          if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0) rx[(c - 6) / 4] = tx;
          if (c == 38) check("stop_bit", tx, 1'b1);
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_unexpected act=%0h exp=none", rx);
          end else begin
            check("rx_byte", rx, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] d;
    logic [39:0] frame;
    logic        exp_bit;
    logic        done;
    int          t0;

    reset = 1'b0;
    bus.address_to_mem = 32'h0;
    bus.data_to_mem    = 32'h0;
    bus.write_enable   = 1'b0;

    // reset state
    repeat (2) begin
      @(negedge clk);
      check("tx_in_reset", tx, 1'b1);
    end
    reset = 1'b1;
    cpu_read(BASE + 32'h4, d);
    check("status_after_reset", d, 32'h4);
    check("state_after_reset", dbg_state, IDLE);

    // single frame 0xA5: start 0, bits 1,0,1,0,0,1,0,1, stop 1
    frame = {4'hF, {4{1'b1}}, {4{1'b0}}, {4{1'b1}}, {4{1'b0}},
             {4{1'b0}}, {4{1'b1}}, {4{1'b0}}, {4{1'b1}}, 4'h0};
    exp_q.push_back(8'hA5);
    cpu_write(BASE, 32'h0000_00A5);
    check("tx_before_pop", tx, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp_bit = frame[i];
      if (tx !== exp_bit) check($sformatf("a5_cycle%0d", i), tx, exp_bit);
      else n_tests++;
    end
    @(negedge clk);
    cpu_read(BASE + 32'h4, d);
    check("a5_idle_status", d, 32'h4);

    // burst of five, then a dropped sixth
    for (int b = 1; b <= 5; b++) begin
      exp_q.push_back(8'(b));
      cpu_write(BASE, b);
      if (b == 1) t0 = cyc;
    end
    cpu_read(BASE + 32'h4, d);
    check("burst_full", d, 32'h43);
    cpu_write(BASE, 32'h06);
    cpu_read(BASE + 32'h4, d);
    check("burst_overflow", d, 32'h4B);
    cpu_write(BASE + 32'h4, 32'h8);
    cpu_read(BASE + 32'h4, d);
    check("ovf_clear", d, 32'h43);

    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      cpu_read(BASE + 32'h4, d);
      if (!d[STAT_BUSY]) done = 1'b1;
    end
    check("burst_done", done, 1'b1);
    check("burst_cycles", cyc - t0, 201);
    check("burst_end_status", d, 32'h4);

    // asynchronous reset in the middle of a frame
    cpu_write(BASE, 32'h3C);
    repeat (12) @(negedge clk);
    check("mid_frame_state", dbg_state, DATA);
    reset = 1'b0;
    #1;
    check("tx_async_reset", tx, 1'b1);
    check("state_async_reset", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cpu_read(BASE + 32'h4, d);
    check("status_after_abort", d, 32'h4);
    expect_idle_line("no_residual_frame", 60);

    // reserved and out-of-window accesses
    cpu_write(BASE + 32'h8, 32'h77);
    cpu_read(BASE + 32'h4, d);
    check("reserved_no_push", d, 32'h4);
    cpu_read(BASE + 32'h8, d);
    check("reserved_read", d, 32'h0);
    cpu_read(BASE, d);
    check("txdata_read", d, 32'h0);
    cpu_write(BASE - 32'h4, 32'h55);
    bus.address_to_mem = BASE - 32'h4;
    #1;
    check("below_sel", bus.sel, 1'b0);
    check("below_read", bus.read_data, 32'h0);
    cpu_read(BASE + 32'h4, d);
    check("below_no_push", d, 32'h4);
    cpu_read(BASE + 32'hC, d);
    check("window_sel", bus.sel, 1'b1);
    expect_idle_line("line_quiet", 60);

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
